mac_accum_bank: RTL and testbench

//   Multi-lane multiply-accumulate result bank for the matrix engine. It is the

---
 rtl/mac_accum_bank.sv | 97 +++++++++
 tb/tb_mac_accum_bank.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/mac_accum_bank.sv
// Multi-lane multiply-accumulate result bank: sums DEPTH beats per lane, then holds the row until taken.
// Optional feature macro: MAC_SAT_EN (saturating lanes with sticky per-lane ovf); default build wraps.
module mac_accum_bank #(
  parameter  int IN_W  = 8,
  parameter  int ACC_W = 10,
  parameter  int LANES = 4,
  parameter  int DEPTH = 4,
  localparam int CNT_W = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   clear,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [LANES*IN_W-1:0]  in_data,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [LANES*ACC_W-1:0] out_data,
  output logic [CNT_W-1:0]       beat_cnt,
  output logic [LANES-1:0]       ovf
);

  localparam logic [0:0]       ST_ACC    = 1'b0;
  localparam logic [0:0]       ST_DONE   = 1'b1;
  localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(DEPTH - 1);

  logic [0:0]       state;
  logic [ACC_W-1:0] acc      [LANES];
  logic [ACC_W-1:0] acc_next [LANES];
  logic             accept;
  logic             row_done;
  logic             take;

  assign in_ready  = (state == ST_ACC) && !clear;
  assign out_valid = (state == ST_DONE);
  assign accept    = in_valid && in_ready;
  assign row_done  = (beat_cnt == LAST_BEAT);
  assign take      = out_valid && out_ready;

`ifdef MAC_SAT_EN
  logic [ACC_W:0]   sum [LANES];
  logic [LANES-1:0] lane_ovf;

  // One extra carry bit per lane detects overflow; the lane then pins at all-ones.
  always_comb begin
    // NOTE: every output of a combinational block gets a default first so no latch is inferred.
    lane_ovf = '0;
    for (int i = 0; i < LANES; i++) begin
      sum[i]      = {1'b0, acc[i]} + (ACC_W+1)'(in_data[i*IN_W +: IN_W]);
      lane_ovf[i] = sum[i][ACC_W];
      acc_next[i] = sum[i][ACC_W] ? '1 : sum[i][ACC_W-1:0];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)      ovf <= '0;
    else if (clear)  ovf <= '0;
    else if (accept) ovf <= ovf | lane_ovf;
    else if (take)   ovf <= '0;
  end
`else
  always_comb begin
    for (int i = 0; i < LANES; i++) begin
      acc_next[i] = acc[i] + ACC_W'(in_data[i*IN_W +: IN_W]);
    end
  end

  assign ovf = '0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= ST_ACC;
      beat_cnt <= '0;
      // NOTE: the accumulator array is reset explicitly; out_data must read zero during reset.
      for (int i = 0; i < LANES; i++) acc[i] <= '0;
    end else if (clear) begin
      state    <= ST_ACC;
      beat_cnt <= '0;
      for (int i = 0; i < LANES; i++) acc[i] <= '0;
    end else if (accept) begin
      // NOTE: non-blocking assignments keep every register update on the same clock edge.
      for (int i = 0; i < LANES; i++) acc[i] <= acc_next[i];
      beat_cnt <= row_done ? '0 : beat_cnt + CNT_W'(1);
      if (row_done) state <= ST_DONE;
    end else if (take) begin
      state <= ST_ACC;
      for (int i = 0; i < LANES; i++) acc[i] <= '0;
    end
  end

  always_comb begin
    out_data = '0;
    for (int i = 0; i < LANES; i++) out_data[i*ACC_W +: ACC_W] = acc[i];
  end

endmodule

// File: tb/tb_mac_accum_bank.sv
// Self-checking bench for mac_accum_bank: directed rows, randomized traffic against a sum model,
// and a DEPTH=8 instance for the overflow row.
module tb_mac_accum_bank;

  localparam int IN_W    = 8;
  localparam int ACC_W   = 10;
  localparam int LANES   = 4;
  localparam int DEPTH   = 4;
  localparam int CNT_W   = 2;
  localparam int CNT8_W  = 3;
  localparam int ACC_MAX = (1 << ACC_W) - 1;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic                   clear, in_valid, out_ready, in_ready, out_valid;
  logic [LANES*IN_W-1:0]  in_data;
  logic [LANES*ACC_W-1:0] out_data;
  logic [CNT_W-1:0]       beat_cnt;
  logic [LANES-1:0]       ovf;

  logic                   d8_clear, d8_in_valid, d8_out_ready, d8_in_ready, d8_out_valid;
  logic [LANES*IN_W-1:0]  d8_in_data;
  logic [LANES*ACC_W-1:0] d8_out_data;
  logic [CNT8_W-1:0]      d8_beat_cnt;
  logic [LANES-1:0]       d8_ovf;

  mac_accum_bank #(.IN_W(IN_W), .ACC_W(ACC_W), .LANES(LANES), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n), .clear(clear), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .beat_cnt(beat_cnt), .ovf(ovf));

  mac_accum_bank #(.IN_W(IN_W), .ACC_W(ACC_W), .LANES(LANES), .DEPTH(8)) dut8 (
    .clk(clk), .rst_n(rst_n), .clear(d8_clear), .in_valid(d8_in_valid), .in_ready(d8_in_ready),
    .in_data(d8_in_data), .out_valid(d8_out_valid), .out_ready(d8_out_ready), .out_data(d8_out_data),
    .beat_cnt(d8_beat_cnt), .ovf(d8_ovf));

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: true (unbounded) lane sums, beats seen in the row, and whether a row is held.
  int m_sum [LANES];
  int m_cnt;
  bit m_hold;
  bit mon_en = 1'b0;

  function automatic int lane_view(input int s);
`ifdef MAC_SAT_EN
    return (s > ACC_MAX) ? ACC_MAX : s;
`else
    return s % (ACC_MAX + 1);
`endif
  endfunction

  function automatic bit lane_ovf_exp(input int s);
`ifdef MAC_SAT_EN
    return s > ACC_MAX;
`else
    return 1'b0;
`endif
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n || clear) begin
      for (int i = 0; i < LANES; i++) m_sum[i] <= 0;
      m_cnt  <= 0;
      m_hold <= 1'b0;
    end else if (!m_hold && in_valid) begin
      for (int i = 0; i < LANES; i++) m_sum[i] <= m_sum[i] + int'(in_data[i*IN_W +: IN_W]);
      m_cnt  <= (m_cnt == DEPTH - 1) ? 0 : m_cnt + 1;
      m_hold <= (m_cnt == DEPTH - 1);
    end else if (m_hold && out_ready) begin
      for (int i = 0; i < LANES; i++) m_sum[i] <= 0;
      m_hold <= 1'b0;
    end
  end

  always @(negedge clk) begin
    if (mon_en) begin
      check("out_valid", 64'(out_valid), 64'(m_hold));
      check("in_ready", 64'(in_ready), 64'(!m_hold && !clear));
      check("beat_cnt", 64'(beat_cnt), 64'(m_cnt));
      for (int i = 0; i < LANES; i++) begin
        check($sformatf("out_data lane%0d", i), 64'(out_data[i*ACC_W +: ACC_W]),
              64'(lane_view(m_sum[i])));
        check($sformatf("ovf lane%0d", i), 64'(ovf[i]), 64'(lane_ovf_exp(m_sum[i])));
      end
    end
  end

  function automatic logic [LANES*IN_W-1:0] all_lanes(input logic [IN_W-1:0] v);
    return {LANES{v}};
  endfunction

  function automatic logic [ACC_W-1:0] lane_of(input logic [LANES*ACC_W-1:0] d, input int k);
    return d[k*ACC_W +: ACC_W];
  endfunction

  task automatic step(input bit v, input logic [LANES*IN_W-1:0] d, input bit c, input bit r);
    in_valid = v; in_data = d; clear = c; out_ready = r;
    @(posedge clk); #1;
  endtask

  task automatic step8(input bit v, input logic [LANES*IN_W-1:0] d, input bit r);
    d8_in_valid = v; d8_in_data = d; d8_out_ready = r;
    @(posedge clk); #1;
  endtask

  initial begin
    logic [ACC_W-1:0] held [LANES];
    logic [ACC_W-1:0] exp8;
    logic [LANES-1:0] exp8_ovf;

    rst_n = 1'b0; clear = 1'b0; in_valid = 1'b0; out_ready = 1'b0; in_data = '0;
    d8_clear = 1'b0; d8_in_valid = 1'b0; d8_out_ready = 1'b0; d8_in_data = '0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    #1;
    check("reset in_ready", 64'(in_ready), 64'd1);
    check("reset out_valid", 64'(out_valid), 64'd0);
    check("reset out_data", 64'(out_data), 64'd0);
    check("reset beat_cnt", 64'(beat_cnt), 64'd0);
    check("reset ovf", 64'(ovf), 64'd0);
    mon_en = 1'b1;

    // Back-to-back row with the consumer always ready.
    for (int k = 1; k <= 4; k++) step(1'b1, {8'd255, 8'd0, 8'd0, 8'(k)}, 1'b0, 1'b1);
    check("row1 out_valid", 64'(out_valid), 64'd1);
    check("row1 lane0", 64'(lane_of(out_data, 0)), 64'd10);
    check("row1 lane3", 64'(lane_of(out_data, 3)), 64'd1020);
    step(1'b0, '0, 1'b0, 1'b1);
    check("row1 out_valid fall", 64'(out_valid), 64'd0);
    check("row1 beat_cnt", 64'(beat_cnt), 64'd0);

    // Completed row held under back-pressure while the producer keeps offering beats.
    for (int k = 0; k < 4; k++) step(1'b1, all_lanes(8'd3), 1'b0, 1'b0);
    for (int k = 0; k < 10; k++) begin
      in_valid = 1'b1; in_data = $urandom; clear = 1'b0; out_ready = 1'b0;
      #1;
      check("hold in_ready", 64'(in_ready), 64'd0);
      check("hold lane2", 64'(lane_of(out_data, 2)), 64'd12);
      check("hold beat_cnt", 64'(beat_cnt), 64'd0);
      @(posedge clk); #1;
    end
    step(1'b0, '0, 1'b0, 1'b1);
    check("hold released", 64'(out_valid), 64'd0);

    // Abort mid-row: the clear-cycle beat is not accepted.
    step(1'b1, all_lanes(8'd7), 1'b0, 1'b0);
    step(1'b1, all_lanes(8'd7), 1'b0, 1'b0);
    step(1'b1, all_lanes(8'd7), 1'b1, 1'b0);
    for (int k = 0; k < 4; k++) step(1'b1, all_lanes(8'd1), 1'b0, 1'b0);
    check("clear row lane0", 64'(lane_of(out_data, 0)), 64'd4);
    check("clear row lane1", 64'(lane_of(out_data, 1)), 64'd4);
    check("clear row valid", 64'(out_valid), 64'd1);
    step(1'b0, '0, 1'b1, 1'b1);
    check("clear drops result", 64'(out_valid), 64'd0);
    check("clear drops data", 64'(out_data), 64'd0);

    // Randomized traffic; the compare process checks every cycle.
    for (int k = 0; k < 3000; k++) begin
      step(($urandom_range(0, 9) < 7), $urandom, ($urandom_range(0, 49) == 0),
           ($urandom_range(0, 1) == 1));
    end
    step(1'b0, '0, 1'b1, 1'b0);

    // Asynchronous reset between clock edges after three beats.
    for (int k = 0; k < 3; k++) step(1'b1, all_lanes(8'd9), 1'b0, 1'b0);
    #2 rst_n = 1'b0;
    #1;
    check("async rst beat_cnt", 64'(beat_cnt), 64'd0);
    check("async rst out_data", 64'(out_data), 64'd0);
    check("async rst out_valid", 64'(out_valid), 64'd0);
    in_valid = 1'b0;
    @(posedge clk); @(posedge clk); #1 rst_n = 1'b1;
    for (int k = 0; k < 3; k++) step(1'b1, all_lanes(8'd2), 1'b0, 1'b0);
    check("post rst 3 beats", 64'(out_valid), 64'd0);
    step(1'b1, all_lanes(8'd2), 1'b0, 1'b0);
    check("post rst 4 beats", 64'(out_valid), 64'd1);
    check("post rst lane3", 64'(lane_of(out_data, 3)), 64'd8);
    for (int i = 0; i < LANES; i++) held[i] = lane_of(out_data, i);
    step(1'b0, '0, 1'b0, 1'b0);
    check("post rst held", 64'(lane_of(out_data, 0)), 64'(held[0]));
    step(1'b0, '0, 1'b0, 1'b1);

    // DEPTH=8 instance: 8 beats of 255 exceed the 10-bit range.
`ifdef MAC_SAT_EN
    exp8 = 10'd1023; exp8_ovf = 4'b1111;
`else
    exp8 = 10'd1016; exp8_ovf = 4'b0000;
`endif
    for (int k = 0; k < 4; k++) step8(1'b1, all_lanes(8'd255), 1'b0);
    check("d8 half beat_cnt", 64'(d8_beat_cnt), 64'd4);
    check("d8 half out_valid", 64'(d8_out_valid), 64'd0);
    for (int k = 0; k < 4; k++) step8(1'b1, all_lanes(8'd255), 1'b0);
    for (int k = 0; k < 3; k++) begin
      check("d8 out_valid", 64'(d8_out_valid), 64'd1);
      check("d8 lane0", 64'(lane_of(d8_out_data, 0)), 64'(exp8));
      check("d8 lane3", 64'(lane_of(d8_out_data, 3)), 64'(exp8));
      check("d8 ovf", 64'(d8_ovf), 64'(exp8_ovf));
      step8(1'b0, '0, 1'b0);
    end
    step8(1'b0, '0, 1'b1);
    check("d8 taken out_valid", 64'(d8_out_valid), 64'd0);
    check("d8 taken ovf", 64'(d8_ovf), 64'd0);
    check("d8 taken data", 64'(d8_out_data), 64'd0);

    mon_en = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
